hdmi_pattern_sequencer: RTL

//  Frame-synchronous controller for the HDMI overlay test-pattern datapath. Runs on the

---
 rtl/hdmi_pattern_sequencer_if.sv | 11 +
 rtl/hdmi_pattern_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hdmi_pattern_sequencer_if.sv
// Config request channel of the HDMI test-pattern sequencer.
// Carries valid/ready, the requested mode and the number of extra frames per ramp step.
interface hdmi_pattern_sequencer_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_hold;

  modport master (output cfg_valid, output cfg_mode, output cfg_hold, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_mode, input cfg_hold, output cfg_ready);
endinterface

// File: rtl/hdmi_pattern_sequencer.sv
// Frame-synchronous test-pattern sequencer: detects VSYNC falls on the pixel clock and steps
// the per-frame overlay colour through off / ramp up / ramp down / solid modes.
module hdmi_pattern_sequencer #(
  parameter logic [7:0] RAMP_MAX   = 8'd255,
  parameter logic [7:0] IDLE_COLOR = 8'd10,
  parameter logic [1:0] DEF_MODE   = 2'd1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           HDMI_TX_VS,
  hdmi_pattern_sequencer_if.slave        cfg,
  output logic [7:0]                     ppe_red,
  output logic [7:0]                     ppe_green,
  output logic [7:0]                     ppe_blue,
  output logic [11:0]                    frame_cnt,
  output logic                           busy
);

  typedef enum logic [1:0] {ST_OFF, ST_RAMP, ST_GAP, ST_SOLID} state_t;

  function automatic state_t mode_state(input logic [1:0] mode);
    case (mode)
      2'd0:    mode_state = ST_OFF;
      2'd3:    mode_state = ST_SOLID;
      default: mode_state = ST_RAMP;
    endcase
  endfunction

  function automatic logic [23:0] pixel(input state_t st, input logic dn, input logic [7:0] step);
    logic [7:0] lvl;
    lvl   = dn ? (RAMP_MAX - step) : step;
    pixel = {3{IDLE_COLOR}};
    case (st)
      ST_RAMP:  pixel = {lvl, lvl - 8'd1, lvl - 8'd1};
      ST_SOLID: pixel = {3{RAMP_MAX}};
      default:  ;
    endcase
  endfunction

  logic       vs_s1_q, vs_s2_q, vs_hist_q, vs_fall_q;
  logic [1:0] settle_q;

  state_t      state_q, state_d;
  logic        dn_q, dn_d;
  logic [7:0]  step_q, step_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [7:0]  hold_q, hold_d;
  logic        pend_vld_q, pend_vld_d;
  logic [1:0]  pend_mode_q, pend_mode_d;
  logic [7:0]  pend_hold_q, pend_hold_d;
  logic [11:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  red_q, red_d, grn_q, grn_d, blu_q, blu_d;

  state_t     eff_state;
  logic       eff_dn;
  logic [7:0] eff_step, eff_hcnt, eff_hold;

  // The chain resets high; edges are only trusted once it has been refilled with real samples,
  // so a VSYNC already low at reset release never looks like a frame boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_s1_q   <= 1'b1;
      vs_s2_q   <= 1'b1;
      vs_hist_q <= 1'b1;
      settle_q  <= 2'd0;
      vs_fall_q <= 1'b0;
    end else begin
      vs_s1_q   <= HDMI_TX_VS;
      vs_s2_q   <= vs_s1_q;
      vs_hist_q <= vs_s2_q;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      vs_fall_q <= vs_hist_q & ~vs_s2_q & (settle_q == 2'd3);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= mode_state(DEF_MODE);
      dn_q        <= (DEF_MODE == 2'd2);
      step_q      <= 8'd0;
      hold_cnt_q  <= 8'd0;
      hold_q      <= 8'd0;
      pend_vld_q  <= 1'b0;
      pend_mode_q <= 2'd0;
      pend_hold_q <= 8'd0;
      frame_cnt_q <= 12'd0;
      red_q       <= IDLE_COLOR;
      grn_q       <= IDLE_COLOR;
      blu_q       <= IDLE_COLOR;
    end else begin
      state_q     <= state_d;
      dn_q        <= dn_d;
      step_q      <= step_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_q      <= hold_d;
      pend_vld_q  <= pend_vld_d;
      pend_mode_q <= pend_mode_d;
      pend_hold_q <= pend_hold_d;
      frame_cnt_q <= frame_cnt_d;
      red_q       <= red_d;
      grn_q       <= grn_d;
      blu_q       <= blu_d;
    end
  end

  // The state registers hold the step that the next frame will show; a pending config
  // replaces it, the frame displays it, and the registers then advance past it.
  always_comb begin
    state_d     = state_q;
    dn_d        = dn_q;
    step_d      = step_q;
    hold_cnt_d  = hold_cnt_q;
    hold_d      = hold_q;
    pend_vld_d  = pend_vld_q;
    pend_mode_d = pend_mode_q;
    pend_hold_d = pend_hold_q;
    frame_cnt_d = frame_cnt_q;
    red_d       = red_q;
    grn_d       = grn_q;
    blu_d       = blu_q;

    eff_state = state_q;
    eff_dn    = dn_q;
    eff_step  = step_q;
    eff_hcnt  = hold_cnt_q;
    eff_hold  = hold_q;
    if (pend_vld_q) begin
      eff_state = mode_state(pend_mode_q);
      eff_dn    = (pend_mode_q == 2'd2);
      eff_step  = 8'd0;
      eff_hcnt  = 8'd0;
      eff_hold  = pend_hold_q;
    end

    if (cfg.cfg_valid && !pend_vld_q) begin
      pend_vld_d  = 1'b1;
      pend_mode_d = cfg.cfg_mode;
      pend_hold_d = cfg.cfg_hold;
    end

    if (vs_fall_q) begin
      frame_cnt_d           = frame_cnt_q + 12'd1;
      {red_d, grn_d, blu_d} = pixel(eff_state, eff_dn, eff_step);
      state_d               = eff_state;
      dn_d                  = eff_dn;
      step_d                = eff_step;
      hold_cnt_d            = eff_hcnt;
      hold_d                = eff_hold;
      if (pend_vld_q) pend_vld_d = 1'b0;
      case (eff_state)
        ST_RAMP: begin
          if (eff_hcnt < eff_hold) begin
            hold_cnt_d = eff_hcnt + 8'd1;
          end else begin
            hold_cnt_d = 8'd0;
            if (eff_step < RAMP_MAX) begin
              step_d = eff_step + 8'd1;
            end else begin
              state_d = ST_GAP;
              step_d  = 8'd0;
            end
          end
        end
        ST_GAP: begin
          state_d    = ST_RAMP;
          step_d     = 8'd0;
          hold_cnt_d = 8'd0;
        end
        default: ;
      endcase
    end
  end

  assign cfg.cfg_ready = ~pend_vld_q;
  assign ppe_red       = red_q;
  assign ppe_green     = grn_q;
  assign ppe_blue      = blu_q;
  assign frame_cnt     = frame_cnt_q;
  assign busy          = (state_q != ST_OFF);

endmodule
